// File: rtl/kb_decode_pkg.sv
// Shared types and constants for the keyboard ASCII-decimal decode path.
package kb_decode_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CONV = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

endpackage

// File: rtl/ascii_digit.sv
// Combinational ASCII character to BCD digit mapper with validity flag.
module ascii_digit
    import kb_decode_pkg::*;
(
    input  logic [7:0] ch,
    output logic [3:0] value,
    output logic       is_digit
);

    always_comb begin
        is_digit = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
        // Within '0'..'9' the low nibble equals ch - 8'h30.
        value    = is_digit ? ch[3:0] : 4'd0;
    end

endmodule

// File: rtl/ascii_decimal_decoder.sv
// Sequential ASCII-decimal to binary converter, one digit per clock, valid/ready both sides.
// Define KB_DECODE_SAT_EN to clamp the result to all-ones on overflow instead of wrapping.
module ascii_decimal_decoder
    import kb_decode_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned OUT_W    = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*N_DIGITS-1:0] buffer,
    input  logic                  buffer_valid,
    output logic                  in_ready,
    output logic [OUT_W-1:0]      buff_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic                  ovf
);

    localparam int unsigned CNT_W = $clog2(N_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [8*N_DIGITS-1:0]   shreg_q, shreg_d;
    logic [OUT_W-1:0]        acc_q, acc_d;
    logic                    err_q, err_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [3:0]              digit;
    logic                    is_digit;
    logic [OUT_W+3:0]        acc_ext;
    logic [OUT_W+3:0]        acc_next;
    logic                    carry;

    ascii_digit u_ascii_digit (
        .ch       (shreg_q[8*N_DIGITS-1 -: 8]),
        .value    (digit),
        .is_digit (is_digit)
    );

    // acc*10 + d, with four guard bits to catch the overflow.
    always_comb begin
        acc_ext  = {4'b0000, acc_q};
        acc_next = (acc_ext << 3) + (acc_ext << 1) + {{OUT_W{1'b0}}, digit};
        carry    = |acc_next[OUT_W+3:OUT_W];
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (buffer_valid) begin
                    shreg_d = buffer;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shreg_d = shreg_q << 8;
                if (!is_digit) err_d = 1'b1;
                if (carry)     ovf_d = 1'b1;
`ifdef KB_DECODE_SAT_EN
                acc_d = (ovf_q || carry) ? {OUT_W{1'b1}} : acc_next[OUT_W-1:0];
`else
                acc_d = acc_next[OUT_W-1:0];
`endif
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE) && !rst;
        out_valid  = (state_q == DONE);
        buff_value = acc_q;
        err        = err_q;
        ovf        = ovf_q;
    end

endmodule

// File: tb/tb_ascii_decimal_decoder.sv
// Self-checking bench for ascii_decimal_decoder: 18-bit and 10-bit instances vs a decimal model.
module tb_ascii_decimal_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] buffer = '0;
    logic        buffer_valid = 1'b0;
    logic        in_ready;
    logic [17:0] buff_value;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        err;
    logic        ovf;

    logic [31:0] buffer10 = '0;
    logic        buffer_valid10 = 1'b0;
    logic        in_ready10;
    logic [9:0]  buff_value10;
    logic        out_valid10;
    logic        out_ready10 = 1'b1;
    logic        err10;
    logic        ovf10;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ascii_decimal_decoder #(.N_DIGITS(4), .OUT_W(18)) dut (
        .clk          (clk),
        .rst          (rst),
        .buffer       (buffer),
        .buffer_valid (buffer_valid),
        .in_ready     (in_ready),
        .buff_value   (buff_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err          (err),
        .ovf          (ovf)
    );

    ascii_decimal_decoder #(.N_DIGITS(4), .OUT_W(10)) dut10 (
        .clk          (clk),
        .rst          (rst),
        .buffer       (buffer10),
        .buffer_valid (buffer_valid10),
        .in_ready     (in_ready10),
        .buff_value   (buff_value10),
        .out_valid    (out_valid10),
        .out_ready    (out_ready10),
        .err          (err10),
        .ovf          (ovf10)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decimal value of the text, non-digits counted as 0, then folded into w bits.
    function automatic void model(input logic [31:0] b, input int w,
                                  output longint v, output bit e, output bit o);
        longint t = 0;
        longint maxv = (longint'(1) << w) - 1;
        e = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            int c = int'(b[8*i +: 8]);
            if (c >= 48 && c <= 57) t = t * 10 + (c - 48);
            else begin
                t = t * 10;
                e = 1'b1;
            end
        end
        o = (t > maxv);
`ifdef KB_DECODE_SAT_EN
        v = o ? maxv : t;
`else
        v = t % (maxv + 1);
`endif
    endfunction

    task automatic run18(input logic [31:0] b, output longint v, output bit e, output bit o,
                         output int lat, output bit to);
        int n = 0;
        buffer = b;
        buffer_valid = 1'b1;
        while (!in_ready && n < 20) begin step(); n++; end
        step();
        buffer_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        to = !out_valid;
        v = longint'(buff_value);
        e = err;
        o = ovf;
        step();
    endtask

    task automatic run10(input logic [31:0] b, output longint v, output bit e, output bit o,
                         output bit to);
        int n = 0;
        int lat = 0;
        buffer10 = b;
        buffer_valid10 = 1'b1;
        while (!in_ready10 && n < 20) begin step(); n++; end
        step();
        buffer_valid10 = 1'b0;
        while (!out_valid10 && lat < 20) begin step(); lat++; end
        to = !out_valid10;
        v = longint'(buff_value10);
        e = err10;
        o = ovf10;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({out_valid, buff_value, err, ovf, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%0b v=%0d e=%0b o=%0b ir=%0b want all 0",
                     out_valid, buff_value, err, ovf, in_ready);
        end
        total++;
        if ({out_valid10, buff_value10, err10, ovf10, in_ready10} !== '0) begin
            bad++;
            $display("FAIL reset_outputs10: got ov=%0b v=%0d ir=%0b want all 0",
                     out_valid10, buff_value10, in_ready10);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        longint v; bit e, o, to; int lat;
        run18("1234", v, e, o, lat, to);
        total++;
        if (to || lat != 4) begin
            bad++;
            $display("FAIL latency_1234: got %0d (timeout=%0b) want 4", lat, to);
        end
        total++;
        if (v != 1234 || e || o) begin
            bad++;
            $display("FAIL value_1234: got v=%0d e=%0b o=%0b want 1234 0 0", v, e, o);
        end
        run18("12a4", v, e, o, lat, to);
        total++;
        if (to || v != 1204 || e != 1'b1 || o) begin
            bad++;
            $display("FAIL value_12a4: got v=%0d e=%0b o=%0b to=%0b want 1204 1 0", v, e, o, to);
        end
    endtask

    task automatic test_overflow();
        longint v, mv; bit e, o, me, mo, to;
        run10("9999", v, e, o, to);
`ifdef KB_DECODE_SAT_EN
        mv = 1023;
`else
        mv = 783;
`endif
        total++;
        if (to || v != mv || o != 1'b1 || e) begin
            bad++;
            $display("FAIL ovf_9999: got v=%0d o=%0b e=%0b want %0d 1 0", v, o, e, mv);
        end
        run10("0999", v, e, o, to);
        model("0999", 10, mv, me, mo);
        total++;
        if (to || v != mv || o != mo || e != me) begin
            bad++;
            $display("FAIL ovf_0999: got v=%0d o=%0b want %0d %0b", v, o, mv, mo);
        end
    endtask

    task automatic test_stall();
        int lat = 0;
        out_ready = 1'b0;
        buffer = "0042";
        buffer_valid = 1'b1;
        step();
        buffer_valid = 1'b0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin buffer = "9000"; buffer_valid = 1'b1; end
            else buffer_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || buff_value !== 18'd42 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got ov=%0b v=%0d ir=%0b want 1 42 0",
                         i, out_valid, buff_value, in_ready);
            end
            step();
        end
        buffer_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b1 || buff_value !== 18'd42) begin
            bad++;
            $display("FAIL stall_release: got ov=%0b v=%0d want 1 42", out_valid, buff_value);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stall_after[%0d]: got ov=%0b ir=%0b want 0 1",
                         i, out_valid, in_ready);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        longint v; bit e, o, to; int lat;
        int seen = 0;
        buffer = "5678";
        buffer_valid = 1'b1;
        step();
        buffer_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ready: got %0b want 0", in_ready);
        end
        step();
        total++;
        if ({out_valid, buff_value, err, ovf, in_ready} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got ov=%0b v=%0d e=%0b o=%0b ir=%0b want all 0",
                     out_valid, buff_value, err, ovf, in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_ready_after: got %0b want 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_mid_no_result: got %0d out_valid cycles want 0", seen);
        end
        run18("0007", v, e, o, lat, to);
        total++;
        if (to || v != 7 || e || o) begin
            bad++;
            $display("FAIL after_rst_0007: got v=%0d e=%0b o=%0b want 7 0 0", v, e, o);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        longint res[$];
        buffer = "0000";
        buffer_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (in_ready && buffer_valid) acc_cyc.push_back(cyc);
            if (out_valid) res.push_back(longint'(buff_value));
            step();
            if (acc_cyc.size() == 1) buffer = "9999";
            if (acc_cyc.size() == 2) buffer_valid = 1'b0;
        end
        buffer_valid = 1'b0;
        total++;
        if (res.size() != 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d results want 2", res.size());
        end else begin
            total++;
            if (res[0] != 0 || res[1] != 9999) begin
                bad++;
                $display("FAIL b2b_values: got %0d,%0d want 0,9999", res[0], res[1]);
            end
        end
        total++;
        if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 6) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d accepts gap %0d want 2 gap 6", acc_cyc.size(),
                     acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1);
        end
    endtask

    task automatic test_random();
        longint v, mv; bit e, o, me, mo, to; int lat;
        logic [31:0] b;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) b[8*i +: 8] = 8'($urandom_range(32, 126));
                else b[8*i +: 8] = 8'(48 + $urandom_range(0, 9));
            end
            run18(b, v, e, o, lat, to);
            model(b, 18, mv, me, mo);
            total++;
            if (to || lat != 4 || v != mv || e != me || o != mo) begin
                bad++;
                $display("FAIL rand18[%0d] %h: got v=%0d e=%0b o=%0b lat=%0d want %0d %0b %0b 4",
                         k, b, v, e, o, lat, mv, me, mo);
            end
            run10(b, v, e, o, to);
            model(b, 10, mv, me, mo);
            total++;
            if (to || v != mv || e != me || o != mo) begin
                bad++;
                $display("FAIL rand10[%0d] %h: got v=%0d e=%0b o=%0b want %0d %0b %0b",
                         k, b, v, e, o, mv, me, mo);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
